demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_data, input, WIDTH bits: the input word.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data and in_sel are valid.
REQ-006 SHALL have port in_sel, input, 1 bit: destination select; 1 selects output 0 and 0 selects output 1 (same polarity as the team's 2:1 selector).
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept the word this cycle.
REQ-008 SHALL have ports out0_data, output, WIDTH bits; out0_valid, output, 1 bit; out0_ready, input, 1 bit: the output-0 stream.
REQ-009 SHALL have ports out1_data, output, WIDTH bits; out1_valid, output, 1 bit; out1_ready, input, 1 bit: the output-1 stream.
REQ-010 SHALL have ports cnt0 and cnt1, outputs, 16 bits each, present only with DEMUX_CNT_EN: transfer counts for output 0 and output 1.

Function
REQ-011 SHALL transfer on a port when valid and ready are both 1 at a rising edge.
REQ-012 SHALL give each output its own 2-entry FIFO, with states EMPTY, ONE and TWO.
REQ-013 SHALL drive in_ready combinationally as 1 when the FIFO addressed by in_sel is not in state TWO.
- in_ready SHALL NOT depend on in_valid.
REQ-014 SHALL write an accepted word only into the addressed FIFO; the other FIFO is unchanged.
REQ-015 SHALL take exactly 1 cycle from acceptance to outN_valid=1 with an empty FIFO.
- No combinational path from in_data to outN_data.
REQ-016 SHALL drive outN_valid as 1 when FIFO N is not EMPTY; outN_data SHALL be the oldest entry.
REQ-017 SHALL apply these FIFO state transitions, for push only / pop only / both:
- EMPTY: push -> ONE.
- ONE: push -> TWO; pop -> EMPTY; both -> ONE.
- TWO: pop -> ONE; push is impossible because in_ready=0.
REQ-018 SHALL preserve word order within each output; no ordering is implied between outputs.
REQ-019 SHALL hold outN_data stable while outN_valid=1 and outN_ready=0.
REQ-020 SHALL let a stall on one output block only inputs addressed to it; the other output keeps flowing.
REQ-021 SHALL allow simultaneous pops on both outputs and a push in the same cycle.
REQ-022 SHALL increment cnt0 and cnt1 (with DEMUX_CNT_EN) on each output transfer, wrapping 0xFFFF -> 0x0000.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, set both FIFOs EMPTY, out0_valid=out1_valid=0, out0_data=out1_data=0 and cnt0=cnt1=0.
REQ-024 SHALL drop any words held mid-operation on reset.
REQ-025 SHALL hold in_ready=0 while reset=1.
REQ-026 SHALL allow in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL, when DEMUX_CNT_EN is defined, include the cnt0/cnt1 ports and counters.
REQ-028 SHALL, when DEMUX_CNT_EN is undefined, omit both ports and counter logic; data-path behaviour is identical.

Structure
REQ-029 SHALL place these in the shared package: constant DEMUX_CNT_W=16, the FIFO state encoding (EMPTY=0, ONE=1, TWO=2) and the select constants SEL_OUT0=1 and SEL_OUT1=0.
REQ-030 SHALL implement each 2-entry FIFO with state as one sub-module, demux_fifo2, instantiated twice.

Verification
REQ-031 SHALL check basic routing: after reset, push 0xA5 with in_sel=1 -> out0_valid=1 with 0xA5 the next cycle; out1_valid stays 0.
REQ-032 SHALL check backpressure: out1_ready=0, push 0x11, 0x22, 0x33 with in_sel=0.
- in_ready=0 after the 2nd push.
- Raising out1_ready then delivers 0x11 and 0x22 in order, after which 0x33 is accepted.
REQ-033 SHALL check independence: out0_ready=0 with FIFO 0 in TWO; push 0x44 with in_sel=0 -> accepted, and out1 delivers 0x44.
REQ-034 SHALL check simultaneous push and pop: FIFO 0 in ONE holding 0x01, out0_ready=1, push 0x02 with in_sel=1 -> state stays ONE, out0_data=0x02 the next cycle.
REQ-035 SHALL check reset mid-operation: both FIFOs in TWO, then reset pulse -> both valids 0, cnt0=cnt1=0, in_ready=1 the cycle after release.
REQ-036 SHALL check counter wrap with DEMUX_CNT_EN: force 65,536 transfers on output 1 -> cnt1 returns to 0x0000, cnt0 unchanged.

Source files
------------

// File: rtl/demux_stream_pkg.sv
// demux_stream_pkg: shared constants and FIFO state encoding for demux_stream (counters enabled by DEMUX_CNT_EN)
package demux_stream_pkg;

    localparam int DEMUX_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_state_t;

    localparam logic SEL_OUT0 = 1'b1;
    localparam logic SEL_OUT1 = 1'b0;

endpackage

// File: rtl/demux_stream_fifo2.sv
// demux_fifo2: 2-entry FIFO; rdata is the head register so there is no path from wdata to rdata
module demux_fifo2
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             valid,
    output logic             full,
    output logic [WIDTH-1:0] rdata
);

    fifo_state_t state;
    logic [WIDTH-1:0] tail;

    assign valid = state != EMPTY;
    assign full  = state == TWO;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            rdata <= '0;
            tail  <= '0;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    rdata <= wdata;
                    state <= ONE;
                end
                ONE: if (push && pop) begin
                    rdata <= wdata;
                end else if (push) begin
                    tail  <= wdata;
                    state <= TWO;
                end else if (pop) begin
                    state <= EMPTY;
                end
                TWO: if (pop) begin
                    rdata <= tail;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/demux_stream.sv
// demux_stream: 1-to-2 stream demultiplexer with a 2-entry FIFO per output; DEMUX_CNT_EN adds cnt0/cnt1
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef DEMUX_CNT_EN
    output logic [DEMUX_CNT_W-1:0] cnt0,
    output logic [DEMUX_CNT_W-1:0] cnt1,
`endif
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_sel,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out0_data,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [WIDTH-1:0]       out1_data,
    output logic                   out1_valid,
    input  logic                   out1_ready
);

    logic full0, full1, push0, push1, pop0, pop1;

    assign in_ready = !reset && !(in_sel == SEL_OUT0 ? full0 : full1);
    assign push0    = in_valid && in_ready && in_sel == SEL_OUT0;
    assign push1    = in_valid && in_ready && in_sel == SEL_OUT1;
    assign pop0     = out0_valid && out0_ready;
    assign pop1     = out1_valid && out1_ready;

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .pop   (pop0),
        .wdata (in_data),
        .valid (out0_valid),
        .full  (full0),
        .rdata (out0_data)
    );

    demux_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .pop   (pop1),
        .wdata (in_data),
        .valid (out1_valid),
        .full  (full1),
        .rdata (out1_data)
    );

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt0 + DEMUX_CNT_W'(pop0);
            cnt1 <= cnt1 + DEMUX_CNT_W'(pop1);
        end
    end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed and random checks of demux_stream against a queue-based model
module tb_demux_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid, in_sel, in_ready;
    logic [7:0] out0_data, out1_data;
    logic       out0_valid, out0_ready, out1_valid, out1_ready;
`ifdef DEMUX_CNT_EN
    logic [15:0] cnt0, cnt1;
`endif

    int vectors = 0;
    int miscompares = 0;
    int n1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [15:0] m_cnt0 = 16'd0, m_cnt1 = 16'd0;

    always #5 clk = ~clk;

    demux_stream #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef DEMUX_CNT_EN
        .cnt0       (cnt0),
        .cnt1       (cnt1),
`endif
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
    endtask

    // One clock: check every output against the model, then advance the model by the edge's transfers
    task automatic cycle();
        logic rdy, p0, p1, pu;
        #1;
        rdy = !reset && ((in_sel ? q0.size() : q1.size()) < 2);
        chk("in_ready", in_ready, rdy);
        chk("out0_valid", out0_valid, q0.size() > 0);
        chk("out1_valid", out1_valid, q1.size() > 0);
        if (q0.size() > 0) chk("out0_data", out0_data, q0[0]);
        if (q1.size() > 0) chk("out1_data", out1_data, q1[0]);
`ifdef DEMUX_CNT_EN
        chk("cnt0", cnt0, m_cnt0);
        chk("cnt1", cnt1, m_cnt1);
`endif
        p0 = q0.size() > 0 && out0_ready;
        p1 = q1.size() > 0 && out1_ready;
        pu = in_valid && rdy;
        @(posedge clk);
        if (reset) begin
            q0.delete();
            q1.delete();
            m_cnt0 = 16'd0;
            m_cnt1 = 16'd0;
        end else begin
            if (p0) begin void'(q0.pop_front()); m_cnt0++; end
            if (p1) begin void'(q1.pop_front()); m_cnt1++; n1++; end
            if (pu && in_sel) q0.push_back(in_data);
            if (pu && !in_sel) q1.push_back(in_data);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1, 8'h00, 1, 1);
        @(posedge clk);
        @(negedge clk);
        cycle();
        reset = 1'b0;
        drive(0, 1, 8'h00, 1, 1);
        chk("ready_after_reset", in_ready, 1);
        // basic routing
        drive(1, 1, 8'hA5, 1, 1);
        cycle();
        drive(0, 1, 8'h00, 1, 1);
        chk("route_v0", out0_valid, 1);
        chk("route_d0", out0_data, 8'hA5);
        chk("route_v1", out1_valid, 0);
        cycle();
        // backpressure on output 1
        drive(1, 0, 8'h11, 1, 0);
        cycle();
        drive(1, 0, 8'h22, 1, 0);
        cycle();
        drive(1, 0, 8'h33, 1, 0);
        chk("bp_full", in_ready, 0);
        cycle();
        drive(1, 0, 8'h33, 1, 1);
        chk("bp_head", out1_data, 8'h11);
        cycle();
        chk("bp_second", out1_data, 8'h22);
        chk("bp_accept", in_ready, 1);
        cycle();
        drive(0, 0, 8'h00, 1, 1);
        chk("bp_third", out1_data, 8'h33);
        cycle();
        // output 0 stalled full, output 1 keeps flowing
        drive(1, 1, 8'hAA, 0, 1);
        cycle();
        drive(1, 1, 8'hBB, 0, 1);
        cycle();
        drive(1, 0, 8'h44, 0, 1);
        chk("indep_ready", in_ready, 1);
        cycle();
        drive(0, 0, 8'h00, 0, 1);
        chk("indep_v1", out1_valid, 1);
        chk("indep_d1", out1_data, 8'h44);
        cycle();
        drive(0, 1, 8'h00, 1, 1);
        repeat (3) cycle();
        // simultaneous push and pop with FIFO 0 holding one word
        drive(1, 1, 8'h01, 0, 1);
        cycle();
        drive(1, 1, 8'h02, 1, 1);
        chk("pp_head", out0_data, 8'h01);
        cycle();
        drive(0, 1, 8'h00, 0, 1);
        chk("pp_valid", out0_valid, 1);
        chk("pp_data", out0_data, 8'h02);
        chk("pp_not_full", in_ready, 1);
        cycle();
        // reset with both FIFOs full
        drive(1, 1, 8'h51, 0, 0); cycle();
        drive(1, 1, 8'h52, 0, 0); cycle();
        drive(1, 0, 8'h61, 0, 0); cycle();
        drive(1, 0, 8'h62, 0, 0); cycle();
        reset = 1'b1;
        drive(0, 1, 8'h00, 0, 0);
        cycle();
        reset = 1'b0;
        drive(0, 1, 8'h00, 0, 0);
        chk("rst_v0", out0_valid, 0);
        chk("rst_v1", out1_valid, 0);
        chk("rst_ready", in_ready, 1);
`ifdef DEMUX_CNT_EN
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
`endif
        cycle();
        // random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
            cycle();
        end
        reset = 1'b0;
`ifdef DEMUX_CNT_EN
        reset = 1'b1;
        drive(0, 0, 8'h00, 1, 1);
        cycle();
        reset = 1'b0;
        n1 = 0;
        for (int i = 0; i < 70000 && n1 < 65536; i++) begin
            drive(1, 0, 8'($urandom), 1, 1);
            cycle();
        end
        drive(0, 0, 8'h00, 0, 0);
        chk("wrap_count", n1, 65536);
        chk("wrap_cnt1", cnt1, 0);
        chk("wrap_cnt0", cnt0, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
